// File: rtl/singcyc_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO
// window with an LED register, a compare timer and a byte TX FIFO.
module singcyc_dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic [7:0]  oLed,
  output logic        oTimerIrq,
  output logic [7:0]  oTxData,
  output logic        oTxValid,
  input  logic        iTxReady
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    REG_LED    = 3'd0,
    REG_TCNT   = 3'd1,
    REG_TCMP   = 3'd2,
    REG_TCTRL  = 3'd3,
    REG_TXDATA = 3'd4,
    REG_TXSTAT = 3'd5
  } regOffset_t;

  logic                  isRam;
  logic                  isMmio;
  logic [ADDR_WIDTH-1:0] wordIdx;
  regOffset_t            regSel;
  logic                  ramWe;
  logic                  mmioWe;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [7:0]  ledReg;
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        tEn;
  logic        tPend;
  logic        tReload;
  logic        timerMatch;

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] txCount;
  logic             txOvf;
  logic             txFull;
  logic             txEmpty;
  logic             txPush;
  logic             txPop;
  logic             txAccept;
  logic [31:0]      txStat;
  logic [31:0]      rData;

  // Address bits outside the decoded fields are aliased away.
  logic unusedAddr;
  assign unusedAddr = ^{iAddr[27:ADDR_WIDTH+2], iAddr[1:0]};

  assign isRam   = (iAddr[31:28] == 4'h0);
  assign isMmio  = (iAddr[31:28] == 4'h4);
  assign wordIdx = iAddr[ADDR_WIDTH+1:2];
  assign regSel  = regOffset_t'(iAddr[4:2]);
  assign ramWe   = iMemWrite && isRam;
  assign mmioWe  = iMemWrite && isMmio;

  assign timerMatch = tEn && (tcnt == tcmp);

  assign txEmpty  = (txCount == '0);
  assign txFull   = (txCount == CNT_W'(FIFO_DEPTH));
  assign txPush   = mmioWe && (regSel == REG_TXDATA);
  assign txPop    = oTxValid && iTxReady;
  assign txAccept = txPush && (!txFull || txPop);
  assign txStat   = {24'h0, 4'(txCount), 1'b0, txOvf, txFull, txEmpty};

  // NOTE: the RAM array has no reset branch; clearing a memory would turn it
  // into a huge flop bank, so its contents stay X until the core stores.
  always_ff @(posedge iClk) begin
    if (ramWe) mem[wordIdx] <= iWData;
  end

  always_ff @(posedge iClk) begin
    if (!iRst && txAccept) fifoMem[wrPtr] <= iWData[7:0];
  end

  // NOTE: sequential state uses non-blocking <= so every register samples the
  // pre-edge values, which keeps same-cycle read-old/write-new behaviour.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ledReg  <= '0;
      tcnt    <= '0;
      tcmp    <= 32'hFFFF_FFFF;
      tEn     <= 1'b0;
      tPend   <= 1'b0;
      tReload <= 1'b0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      txCount <= '0;
      txOvf   <= 1'b0;
    end else begin
      if (mmioWe && regSel == REG_LED)  ledReg <= iWData[7:0];
      if (mmioWe && regSel == REG_TCMP) tcmp   <= iWData;

      // A core store to TCNT beats both increment and reload.
      if (mmioWe && regSel == REG_TCNT) tcnt <= iWData;
      else if (tEn)                     tcnt <= (timerMatch && tReload) ? 32'd0 : tcnt + 32'd1;

      if (mmioWe && regSel == REG_TCTRL) begin
        tEn     <= iWData[0];
        tReload <= iWData[2];
      end

      // A fresh match outranks the write-1-clear of PEND.
      if (timerMatch)                                     tPend <= 1'b1;
      else if (mmioWe && regSel == REG_TCTRL && iWData[1]) tPend <= 1'b0;

      if (txAccept) wrPtr <= wrPtr + 1'b1;
      if (txPop)    rdPtr <= rdPtr + 1'b1;

      case ({txAccept, txPop})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: txCount <= txCount;
      endcase

      if (txPush && txFull && !txPop)                       txOvf <= 1'b1;
      else if (mmioWe && regSel == REG_TXSTAT && iWData[2]) txOvf <= 1'b0;
    end
  end

  // NOTE: rData gets a default before any branch so no path infers a latch.
  always_comb begin
    rData = 32'h0;
    if (iMemRead) begin
      if (isRam) begin
        rData = mem[wordIdx];
      end else if (isMmio) begin
        case (regSel)
          REG_LED:    rData = {24'h0, ledReg};
          REG_TCNT:   rData = tcnt;
          REG_TCMP:   rData = tcmp;
          REG_TCTRL:  rData = {29'h0, tReload, tPend, tEn};
          REG_TXSTAT: rData = txStat;
          default:    rData = 32'h0;
        endcase
      end
    end
  end

  assign oRData    = rData;
  assign oLed      = ledReg;
  assign oTimerIrq = tPend;
  assign oTxValid  = !txEmpty;
  assign oTxData   = oTxValid ? fifoMem[rdPtr] : 8'h0;

endmodule

// File: doc/singcyc_dmem_responder.md
Name: singcyc_dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS core. It serves the core's load/store port (address, MemRead, MemWrite, write data, read data).
- Contains a word RAM plus a small memory-mapped peripheral window: LED register, compare timer with interrupt, and byte TX FIFO.
- The core has no stall path, so every read is answered in the same cycle and every write commits at the next rising edge.

Parameters:
- ADDR_WIDTH, 8, log2 of RAM depth in 32-bit words (256 words, byte range 0x000-0x3FF).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  synchronous reset, active-high.
- iAddr  in  32  byte address from core. Bits [1:0] are ignored (word access only).
- iMemRead  in  1  load request, same-cycle response.
- iMemWrite  in  1  store request, committed at next rising edge.
- iWData  in  32  store data.
- oRData  out  32  load data, combinational.
- oLed  out  8  LED register.
- oTimerIrq  out  1  timer interrupt pending.
- oTxData  out  8  FIFO head byte.
- oTxValid  out  1  FIFO not empty.
- iTxReady  in  1  sink accepts byte when high with oTxValid.

Behaviour:
- Decode:
  - RAM when iAddr[31:28]==4'h0. Word index is iAddr[ADDR_WIDTH+1:2]; higher address bits are aliased/ignored.
  - MMIO when iAddr[31:28]==4'h4. Register offset is iAddr[4:2].
  - All other addresses are unmapped: read 0, write ignored.
- Reads:
  - oRData is combinational from iAddr when iMemRead=1, else 32'h0.
  - Read and write to the same location in the same cycle return the old value.
  - RAM is not cleared by reset; it is X until written.
- MMIO map. Bits not listed read 0 and ignore writes.
  - 0x4000_0000 LED: RW [7:0] drives oLed.
  - 0x4000_0004 TCNT: RW 32-bit counter.
  - 0x4000_0008 TCMP: RW 32-bit compare.
  - 0x4000_000C TCTRL: bit0 EN (RW), bit1 PEND (R, write-1-clear), bit2 RELOAD (RW).
  - 0x4000_0010 TXDATA: write pushes iWData[7:0]; reads 0.
  - 0x4000_0014 TXSTAT: R {[7:4]=count, [2]=OVF sticky, [1]=full, [0]=empty}. Writing bit2=1 clears OVF.
- Timer, evaluated each cycle with EN=1:
  - If TCNT==TCMP: PEND<=1; TCNT<=0 if RELOAD, else TCNT+1.
  - Otherwise TCNT+1, wrapping 0xFFFF_FFFF->0.
  - A core write to TCNT overrides the increment/reload in that cycle.
  - PEND set and write-1-clear in the same cycle: set wins.
  - oTimerIrq = PEND.
- TX FIFO:
  - Circular buffer with rd/wr pointers and a count of width log2(FIFO_DEPTH)+1.
  - oTxValid = count!=0. oTxData = entry at rd pointer.
  - Pop when oTxValid&&iTxReady. Push on TXDATA write.
  - Push when full with no pop: byte dropped, OVF<=1.
  - Push and pop in the same cycle (including when full): both occur, count unchanged, no OVF.
  - Push while empty: byte visible on oTxData the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (iRst=1 at clock edge):
  - oLed=0, TCNT=0, TCMP=32'hFFFF_FFFF, TCTRL=0, oTimerIrq=0.
  - FIFO emptied (oTxValid=0, oTxData=0), OVF=0.
  - Reset overrides any same-cycle write or pop.
  - Reset mid-transfer discards queued bytes.
- Latency:
  - Loads: 0 cycles.
  - Stores/side effects: visible 1 cycle later.
  - Timer compare to oTimerIrq: 1 cycle.

Test Plan:
- RAM: store 0xDEADBEEF at 0x0000_0010 -> next cycle load 0x10 returns 0xDEADBEEF. Load 0x0000_0410 (ADDR_WIDTH=8) aliases to the same word. Load 0x8000_0000 returns 0. Same-cycle load/store to 0x14 returns the prior value.
- LED: store 0x1234_56A5 to 0x4000_0000 -> oLed=0xA5; read returns 0x0000_00A5. Assert iRst -> oLed=0.
- Timer with TCMP=3 and TCTRL=0x5 (EN, RELOAD) -> TCNT runs 0,1,2,3,0. PEND/oTimerIrq rises one cycle after TCNT==3. Writing TCTRL=0x7 clears PEND except when a match occurs in the same cycle (PEND stays 1).
- Timer without RELOAD, TCNT=0xFFFF_FFFE, TCMP=5 -> counts ...FFFF, 0, ... 5. PEND is set and the count continues 6.
- FIFO with iTxReady=0: push 0x11,0x22,0x33,0x44,0x55 -> TXSTAT count=4, full=1, OVF=1; oTxData=0x11. Raise iTxReady -> bytes 0x11..0x44 are drained in order, then oTxValid=0.
- FIFO full with iTxReady=1 and a push of 0x66 in the same cycle -> count stays 4, OVF unchanged, 0x66 is last out. Reset asserted with count=3 -> oTxValid=0 the next cycle and TXSTAT reads 0x01.
